// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Scans one digit per prescaler tick. New data is shown only at frame boundaries.
// Optional feature: define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan #(
  parameter int unsigned DIV_BITS = 18,
  parameter int unsigned DIGITS   = 8
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int unsigned CntW = $clog2(DIGITS);

  logic [DIV_BITS-1:0]   presc_q, presc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [4*DIGITS-1:0]   shown_q, shown_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            nibble;
  logic                  lzb_sup;

  // Active-low glyph for one hex nibble, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign tick     = &presc_q;
  assign boundary = tick && (cnt_q == CntW'(DIGITS - 1));
  assign nibble   = shown_q[4*cnt_q +: 4];

`ifdef SEVENSEG_LZB_EN
  logic [CntW-1:0] msnz_q, msnz_d;

  // Index of the most significant nonzero nibble of the shown word (0 if none).
  always_comb begin
    msnz_d = '0;
    for (int i = 1; i < int'(DIGITS); i++) begin
      if (shown_q[4*i +: 4] != 4'h0) msnz_d = CntW'(i);
    end
  end

  // Registered one cycle behind shown; digit 0 is never above msnz.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) msnz_q <= '0;
    else       msnz_q <= msnz_d;
  end

  assign lzb_sup = (cnt_q > msnz_q);
`else
  assign lzb_sup = 1'b0;
`endif

  // Next-state: prescaler, digit index, double-buffered display word, outputs.
  always_comb begin
    presc_d  = presc_q + 1'b1;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    shown_d  = shown_q;

    if (tick) cnt_d = boundary ? '0 : cnt_q + 1'b1;

    if (boundary) begin
      // A load on the boundary itself bypasses and discards the pending word.
      if (load)          shown_d = data;
      else if (pend_v_q) shown_d = pend_q;
      pend_v_d = 1'b0;
    end else if (load) begin
      pend_d   = data;
      pend_v_d = 1'b1;
    end

    // Blanking is by anode only; seg still carries the glyph.
    an_d    = (blank[cnt_q] || lzb_sup) ? '1 : ~(DIGITS'(1) << cnt_q);
    seg_d   = hex_glyph(nibble);
    frame_d = boundary;
  end

  // State and registered outputs.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      shown_q  <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      shown_q  <= shown_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan with DIV_BITS=2 (tick every 4 cycles).
// Expectations are stamped with the clock-edge count since reset release.
module tb_sevenseg_scan;

`ifdef SEVENSEG_LZB_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic        load;
  logic [7:0]  blank;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        frame;

  sevenseg_scan #(.DIV_BITS(2), .DIGITS(8)) dut (
    .CLK100MHZ (clk),
    .reset     (rst),
    .data      (data),
    .load      (load),
    .blank     (blank),
    .seg       (seg),
    .an        (an),
    .frame     (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [6:0] seg;
    logic       frm;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  // Edges since reset release; the stamp used by the scoreboard.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: sample mid-cycle and retire every expectation due at this edge count.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: expectation for edge %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (an !== e.an || seg !== e.seg || frame !== e.frm) begin
        failures++;
        $display("FAIL %s @%0d: got an=%h seg=%b frame=%b, want an=%h seg=%b frame=%b",
                 e.name, cyc, an, seg, frame, e.an, e.seg, e.frm);
      end
    end
  end

  task automatic push(input int c, input logic [7:0] a, input logic [6:0] s, input logic f,
                      input string n);
    exp_t e;
    e.cyc = c; e.an = a; e.seg = s; e.frm = f; e.name = n;
    sb_q.push_back(e);
  endtask

  // Digit d of frame f occupies edges 32f+4d+1 .. +4; frame pulses after the last of digit 7.
  task automatic push_digit(input int f, input int d, input logic [7:0] a, input logic [6:0] s,
                            input string tag);
    for (int o = 0; o < 4; o++) begin
      push(32*f + 4*d + 1 + o, a, s, (d == 7 && o == 3), $sformatf("%s_f%0d_d%0d", tag, f, d));
    end
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present data so it is captured at edge e.
  task automatic do_load(input logic [31:0] d, input int e);
    wait_edge(e - 1);
    data = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    data  = 32'h0;
    blank = 8'h00;

    push(0, 8'hFF, 7'h7F, 1'b0, "reset_state");
    // Frame 0: shown = 0.
    for (int d = 0; d < 8; d++)
      push_digit(0, d, (Lzb && d > 0) ? 8'hFF : an_tab[d], glyph[0], "zero");
    // Frame 1: 76543210 loaded mid frame 0.
    for (int d = 0; d < 8; d++) push_digit(1, d, an_tab[d], glyph[d], "count");
    // Frame 2: last of two loads wins (all F), digit 7 blanked by mask.
    for (int d = 0; d < 8; d++)
      push_digit(2, d, (d == 7) ? 8'hFF : an_tab[d], glyph[15], "allf_blank");
    // Frame 3/4: boundary load 89ABCDEF, pending 12345678 discarded.
    for (int d = 0; d < 8; d++) push_digit(3, d, an_tab[d], glyph[15-d], "bload");
    for (int d = 0; d < 5; d++) push_digit(4, d, an_tab[d], glyph[15-d], "bload_hold");
    push(149, an_tab[5], glyph[10], 1'b0, "pre_reset_d5");

    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_load(32'h76543210, 10);
    do_load(32'h99999999, 40);
    do_load(32'hFFFFFFFF, 46);
    wait_edge(64);
    blank = 8'h80;
    do_load(32'h12345678, 70);
    do_load(32'h89ABCDEF, 96);
    blank = 8'h00;

    // Mid-frame reset at digit 5; the next negedge must see reset outputs.
    wait_edge(150);
    push(0, 8'hFF, 7'h7F, 1'b0, "reset_midframe");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 8; d++)
      push_digit(0, d, (Lzb && d > 0) ? 8'hFF : an_tab[d], glyph[0], "restart");
    push_digit(1, 0, an_tab[0], glyph[5], "lzb");
    push_digit(1, 1, an_tab[1], glyph[0], "lzb");
    push_digit(1, 2, an_tab[2], glyph[10], "lzb");
    for (int d = 3; d < 8; d++) push_digit(1, d, Lzb ? 8'hFF : an_tab[d], glyph[0], "lzb");
    rst = 1'b0;

    do_load(32'h00000A05, 10);
    wait_edge(66);
    @(negedge clk);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d expectations never sampled, want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
